perceptron_weight_loader: RTL and testbench

PERCEPTRON_WEIGHT_LOADER -- requirements
Module: perceptron_weight_loader

---
 rtl/perceptron_weight_loader.sv | 163 ++++++++++++++++
 tb/tb_perceptron_weight_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_weight_loader.sv
// Serial weight loader: captures a bias word and two weight words, then
// streams them MSB first to a perceptron datapath (bias, then W0, then W1).
// Every output is a register, loaded from the next-state decode so that the
// outputs always describe the state the FSM is in.
module perceptron_weight_loader #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load_valid_i,
   output logic                    load_ready_o,
   input  logic signed [WIDTH-1:0] b_par_i,
   input  logic signed [WIDTH-1:0] W0_par_i,
   input  logic signed [WIDTH-1:0] W1_par_i,
   output logic [1:0]              W1W0b_en_o,
   output logic                    b_o,
   output logic                    W0_o,
   output logic                    W1_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // The encoding matches the target-select code driven while in each state.
   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SHIFT_B  = 2'b01,
      SHIFT_W0 = 2'b10,
      SHIFT_W1 = 2'b11
   } state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [CW-1:0]    bit_idx;
   logic [WIDTH-1:0] b_word_reg, b_word_next;
   logic [WIDTH-1:0] w0_word_reg, w0_word_next;
   logic [WIDTH-1:0] w1_word_reg, w1_word_next;

   logic       ready_reg, ready_next;
   logic [1:0] en_reg, en_next;
   logic       b_bit_reg, b_bit_next;
   logic       w0_bit_reg, w0_bit_next;
   logic       w1_bit_reg, w1_bit_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;

   // Next-state, capture and registered-output decode.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      b_word_next  = b_word_reg;
      w0_word_next = w0_word_reg;
      w1_word_next = w1_word_reg;
      done_next    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (load_valid_i) begin
               b_word_next  = b_par_i;
               w0_word_next = W0_par_i;
               w1_word_next = W1_par_i;
               cnt_next     = '0;
               state_next   = SHIFT_B;
            end
         end
         SHIFT_B: begin
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = SHIFT_W0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SHIFT_W0: begin
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = SHIFT_W1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         SHIFT_W1: begin
            if (cnt_reg == LAST) begin
               cnt_next   = '0;
               state_next = IDLE;
               done_next  = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      // Bit sent in the coming cycle: MSB first, indexed by the next count.
      bit_idx     = LAST - cnt_next;
      en_next     = 2'b00;
      b_bit_next  = 1'b0;
      w0_bit_next = 1'b0;
      w1_bit_next = 1'b0;
      case (state_next)
         SHIFT_B: begin
            en_next    = 2'b01;
            b_bit_next = b_word_next[bit_idx];
         end
         SHIFT_W0: begin
            en_next     = 2'b10;
            w0_bit_next = w0_word_next[bit_idx];
         end
         SHIFT_W1: begin
            en_next     = 2'b11;
            w1_bit_next = w1_word_next[bit_idx];
         end
         default: en_next = 2'b00;
      endcase
      ready_next = (state_next == IDLE);
      busy_next  = (state_next != IDLE);
   end

   // State, counter, captured words and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         b_word_reg  <= '0;
         w0_word_reg <= '0;
         w1_word_reg <= '0;
         ready_reg   <= 1'b1;
         en_reg      <= 2'b00;
         b_bit_reg   <= 1'b0;
         w0_bit_reg  <= 1'b0;
         w1_bit_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         b_word_reg  <= b_word_next;
         w0_word_reg <= w0_word_next;
         w1_word_reg <= w1_word_next;
         ready_reg   <= ready_next;
         en_reg      <= en_next;
         b_bit_reg   <= b_bit_next;
         w0_bit_reg  <= w0_bit_next;
         w1_bit_reg  <= w1_bit_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   assign load_ready_o = ready_reg;
   assign W1W0b_en_o   = en_reg;
   assign b_o          = b_bit_reg;
   assign W0_o         = w0_bit_reg;
   assign W1_o         = w1_bit_reg;
   assign busy_o       = busy_reg;
   assign done_o       = done_reg;

endmodule

// File: tb/tb_perceptron_weight_loader.sv
// Scoreboard bench for perceptron_weight_loader: a transfer-level model pushes
// the expected per-cycle serial stream on each accepted request; a monitor
// pops and compares whenever the loader drives a word bit or done_o, and a
// left-shifting receiver checks that each full word arrives intact.
module tb_perceptron_weight_loader;

   localparam int W = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                load_valid_i = 1'b0;
   logic                load_ready_o;
   logic signed [W-1:0] b_par_i = '0;
   logic signed [W-1:0] W0_par_i = '0;
   logic signed [W-1:0] W1_par_i = '0;
   logic [1:0]          W1W0b_en_o;
   logic                b_o, W0_o, W1_o, busy_o, done_o;

   perceptron_weight_loader #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .load_valid_i (load_valid_i),
      .load_ready_o (load_ready_o),
      .b_par_i      (b_par_i),
      .W0_par_i     (W0_par_i),
      .W1_par_i     (W1_par_i),
      .W1W0b_en_o   (W1W0b_en_o),
      .b_o          (b_o),
      .W0_o         (W0_o),
      .W1_o         (W1_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [1:0] en;
      logic       b, w0, w1, done;
      logic [W-1:0] bw, w0w, w1w;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   free_cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   n_xfer = 0;
   logic [W-1:0] rx_b = '0, rx_w0 = '0, rx_w1 = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected stream for a transfer accepted at the edge ending cycle n.
   task automatic push_transfer(input int n, input logic [W-1:0] bw,
                                input logic [W-1:0] w0w, input logic [W-1:0] w1w);
      exp_t e;
      for (int k = 0; k < 3*W; k++) begin
         int word = k / W;
         int j    = k % W;
         e.cyc  = n + 1 + k;
         e.en   = 2'(word + 1);
         e.b    = (word == 0) ? bw[W-1-j]  : 1'b0;
         e.w0   = (word == 1) ? w0w[W-1-j] : 1'b0;
         e.w1   = (word == 2) ? w1w[W-1-j] : 1'b0;
         e.done = 1'b0;
         e.bw = bw; e.w0w = w0w; e.w1w = w1w;
         sb_q.push_back(e);
      end
      e.cyc = n + 1 + 3*W; e.en = 2'b00;
      e.b = 1'b0; e.w0 = 1'b0; e.w1 = 1'b0; e.done = 1'b1;
      sb_q.push_back(e);
   endtask

   // Reference model: idle until free_cyc; reset flushes pending work.
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            sb_q.delete();
            free_cyc = cyc + 1;
         end else if (load_valid_i && cyc >= free_cyc) begin
            push_transfer(cyc, b_par_i, W0_par_i, W1_par_i);
            free_cyc = cyc + 1 + 3*W;
         end
         cyc++;
      end
   end

   // Monitor: compare handshake status every cycle, pop on each DUT output.
   initial begin
      exp_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_output: got none expected en=%0d at cycle %0d", sb_q[0].en, sb_q[0].cyc);
            void'(sb_q.pop_front());
         end
         check("load_ready", load_ready_o, (cyc >= free_cyc) ? 1 : 0);
         check("busy", busy_o, (cyc < free_cyc) ? 1 : 0);
         if (W1W0b_en_o != 2'b00 || done_o) begin
            if (sb_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_output: got en=%0d done=%0d expected idle", W1W0b_en_o, done_o);
            end else if (sb_q[0].cyc != cyc) begin
               checks++; errors++;
               $display("FAIL output_timing: got cycle %0d expected cycle %0d", cyc, sb_q[0].cyc);
            end else begin
               e = sb_q.pop_front();
               check("en", W1W0b_en_o, e.en);
               check("b_o", b_o, e.b);
               check("W0_o", W0_o, e.w0);
               check("W1_o", W1_o, e.w1);
               check("done", done_o, e.done);
               if (W1W0b_en_o == 2'b01) rx_b  = {rx_b[W-2:0], b_o};
               if (W1W0b_en_o == 2'b10) rx_w0 = {rx_w0[W-2:0], W0_o};
               if (W1W0b_en_o == 2'b11) rx_w1 = {rx_w1[W-2:0], W1_o};
               if (done_o) begin
                  n_xfer++;
                  check("rx_bias", rx_b, e.bw);
                  check("rx_w0", rx_w0, e.w0w);
                  check("rx_w1", rx_w1, e.w1w);
                  $display("transfer %0d done at cycle %0d: b=%02h w0=%02h w1=%02h",
                           n_xfer, cyc, rx_b, rx_w0, rx_w1);
               end
            end
         end else begin
            check("idle_serial_zero", {b_o, W0_o, W1_o}, 0);
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
               checks++; errors++;
               $display("FAIL missing_output: got en=0 done=0 expected en=%0d done=%0d", sb_q[0].en, sb_q[0].done);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   task automatic scramble();
      b_par_i  = W'($urandom);
      W0_par_i = W'($urandom);
      W1_par_i = W'($urandom);
   endtask

   // One request; parallel inputs are scrambled while the transfer runs.
   task automatic load_one(input logic [W-1:0] bw, input logic [W-1:0] w0w,
                           input logic [W-1:0] w1w);
      @(negedge clk);
      load_valid_i = 1'b1;
      b_par_i = bw; W0_par_i = w0w; W1_par_i = w1w;
      @(negedge clk);
      load_valid_i = 1'b0;
      repeat (3*W + 1) begin
         scramble();
         @(negedge clk);
      end
   endtask

   // Stimulus
   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      load_one(8'h5A, 8'h81, 8'h7F);
      load_one(8'h80, 8'hFF, 8'h00);

      // Back-to-back with valid held high and data changing every cycle.
      @(negedge clk);
      load_valid_i = 1'b1;
      repeat (3*(3*W + 1)) begin
         scramble();
         @(negedge clk);
      end
      load_valid_i = 1'b0;
      repeat (3*W + 2) @(negedge clk);

      // Reset during W0: asserted in cycle 10 after acceptance.
      load_valid_i = 1'b1;
      scramble();
      @(negedge clk);
      load_valid_i = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      load_one(8'hC3, 8'h3C, 8'h01);

      // Reset beats a simultaneous request.
      @(negedge clk);
      reset = 1'b1;
      load_valid_i = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      load_valid_i = 1'b0;
      @(negedge clk);

      // Random traffic with occasional resets.
      repeat (600) begin
         load_valid_i = ($urandom_range(0, 99) < 30);
         reset        = ($urandom_range(0, 199) < 3);
         scramble();
         @(negedge clk);
      end
      reset = 1'b0;
      load_valid_i = 1'b0;
      repeat (3*W + 4) @(negedge clk);

      check("scoreboard_drained", sb_q.size(), 0);
      check("transfers_seen_min", (n_xfer >= 7) ? 1 : 0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
